demux_1n_reg: RTL and testbench
===============================

# demux_1n_reg

Parametrised registered 1:N stream demultiplexer, successor to the combinational 1:2 demux. It routes each accepted input beat (`I`, `S`) to one of N output channels. Each channel has a one-entry output register with valid/ready flow control, so per-channel backpressure is independent of the other channels. It sits between a single producer and N consumers in the datapath, and replaces combinational demux instances wherever a registered, backpressure-aware split is needed.

## Interface
Parameters:
- `N`, 4: number of output channels, ≥ 2.
- `W`, 8: data width, ≥ 1.
- `SW`, `$clog2(N)`: select width. Derived; do not override.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `I`  in  W  input data.
- `S`  in  SW  channel select.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `Y`  out  N*W  channel data, flattened; channel k is `Y[k*W +: W]`.
- `out_valid`  out  N  channel k holds a beat.
- `out_ready`  in  N  consumer k takes the beat this cycle.
- `err_cnt`  out  8  out-of-range select counter. Present only with `DEMUX_ERR_CNT_EN`.

## Operation
- An input beat is accepted when `in_valid && in_ready`.
- Channel k is free when `!out_valid[k] || out_ready[k]`.
- `in_ready` is combinational from `S`, `out_valid` and `out_ready`:
  - `S` < N: `in_ready` = channel S is free.
  - `S` ≥ N (only possible when N is not a power of two): `in_ready` = 1.
- On accept with `S` < N:
  - `Y[S]` ← `I`.
  - `out_valid[S]` ← 1.
- On a drain of channel k (`out_valid[k] && out_ready[k]`) with no accept to channel k in the same cycle: `out_valid[k]` ← 0. `Y[k]` holds its last value.
- Simultaneous drain and accept on the same channel: the register reloads with the new beat and `out_valid` stays 1. No bubble occurs.
- Channels are independent. A stalled channel blocks only beats selected to it. It never blocks beats to other channels, and never blocks the cycle after the select changes.
- `in_ready` may depend on `S`. `in_ready` never depends on `in_valid`.
- Out-of-range beats (`S` ≥ N) are accepted and discarded. No channel changes.
- Reset, asserted at any time including mid-transfer:
  - `out_valid` = 0, `Y` = 0, `err_cnt` = 0, all immediately.
  - Beats held in the channel registers are lost.
  - `in_ready` then follows the rules above, which gives 1 for any select.

## Timing
- Latency: a beat accepted at edge n appears on `Y[S]` with `out_valid[S]` = 1 after edge n.
- Throughput: one beat per cycle sustained to any single channel whose consumer holds `out_ready` = 1.
- Combinational paths:
  - `out_ready` → `in_ready` (one path).
  - `S` → `in_ready` (one path).
- No combinational path from `I` or `in_valid` to any output.
- Registered outputs: `Y`, `out_valid`, `err_cnt`.

## Configuration
- Macro: `DEMUX_ERR_CNT_EN`.
- Defined:
  - Port `err_cnt` exists.
  - It increments by 1 on each accepted beat with `S` ≥ N.
  - It saturates at 8'hFF and clears only on `rst`.
- Undefined:
  - Port `err_cnt` and its register are absent.
  - Out-of-range beats are still accepted and silently discarded.
- When N is a power of two, `err_cnt` stays 0.

## Structure
- Package `demux_pkg`:
  - `DEMUX_N_DEF` = 4, `DEMUX_W_DEF` = 8.
  - `ERR_CNT_W` = 8, `ERR_CNT_MAX` = 8'hFF.
- Sub-module `demux_slot`: the one-entry valid/ready register (load, drain, reload, reset to 0). Instantiated N times from a generate loop.
- Top-level holds the select decode, the `in_ready` mux and the optional error counter.

## Test plan
All scenarios use N = 4, W = 8 unless stated.
1. Reset: assert `rst` mid-stream with `out_valid` = 4'b1010. Required: `out_valid` = 0 and `Y` = 0 immediately, `in_ready` = 1 during reset.
2. Routing: `out_ready` = 4'hF; send `I` = 8'hA0..8'hA3 with `S` = 0..3 back-to-back. Required: each data value on channel S one cycle later, one beat per cycle, `in_ready` = 1 throughout.
3. Backpressure:
   - `out_ready[2]` = 0; send 8'h11 then 8'h22 to `S` = 2. Required: the second beat sees `in_ready` = 0, and `Y[2]` holds 8'h11.
   - Raise `out_ready[2]`. Required: 8'h22 is accepted that cycle and appears the next cycle.
4. Independence: channel 1 stalled and full; send 8'h55 to `S` = 3. Required: accepted immediately, channel 1 unchanged.
5. Same-cycle drain and reload: channel 0 full with 8'h01 and `out_ready[0]` = 1; send 8'h02 to `S` = 0 in the same cycle. Required: `Y[0]` = 8'h02 next cycle, `out_valid[0]` stays 1.
6. Out-of-range select, N = 5 with `DEMUX_ERR_CNT_EN` defined: send 3 beats with `S` = 7. Required: all accepted, no `out_valid` change, `err_cnt` = 3. Then send 300 such beats. Required: `err_cnt` = 8'hFF.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared defaults and error-counter constants for the registered 1:N demultiplexer.
package demux_pkg;
  localparam int DEMUX_N_DEF = 4;
  localparam int DEMUX_W_DEF = 8;
  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;
endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel: load, drain, same-cycle reload.
module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_free
);
  logic         r_valid;
  logic [W-1:0] r_data;

  // A load wins over a drain, so a simultaneous drain and load keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_free  = !r_valid || i_ready;
endmodule

// File: rtl/demux_1n_reg.sv
// Registered 1:N stream demultiplexer with per-channel valid/ready output registers.
// Optional out-of-range select counter enabled by defining DEMUX_ERR_CNT_EN.
module demux_1n_reg
  import demux_pkg::*;
#(
  parameter int N  = DEMUX_N_DEF,
  parameter int W  = DEMUX_W_DEF,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    I,
  input  logic [SW-1:0]   S,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*W-1:0]  Y,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);
  localparam int NS = 1 << SW;

  logic [N-1:0]  w_free;
  logic [N-1:0]  w_load;
  logic [NS-1:0] w_sel_free;
  logic [NS-1:0] w_dec;
  logic          w_accept;

  // Handshake: a beat transfers on any edge where valid && ready. in_ready looks only
  // at S and the selected channel's state, never at in_valid; select codes past N-1
  // map to always-free entries so out-of-range beats are swallowed.
  always_comb begin
    w_sel_free = '1;
    w_sel_free[N-1:0] = w_free;
  end

  assign in_ready = w_sel_free[S];
  assign w_accept = in_valid && in_ready;
  assign w_dec    = NS'(1) << S;
  assign w_load   = w_dec[N-1:0] & {N{w_accept}};

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[k]),
      .i_data  (I),
      .i_ready (out_ready[k]),
      .o_valid (out_valid[k]),
      .o_data  (Y[k*W +: W]),
      .o_free  (w_free[k])
    );
  end

`ifdef DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_oor;

  assign w_oor = w_accept && !(|w_dec[N-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_oor && (r_err_cnt != ERR_CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_demux_1n_reg.sv
// Directed bench for demux_1n_reg: a 4-channel instance and a 5-channel instance
// for out-of-range selects (counter checks when DEMUX_ERR_CNT_EN is defined).
module tb_demux_1n_reg;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  i4;
  logic [1:0]  s4;
  logic        v4;
  logic        rdy4;
  logic [31:0] y4;
  logic [3:0]  ov4;
  logic [3:0]  or4;

  logic [7:0]  i5;
  logic [2:0]  s5;
  logic        v5;
  logic        rdy5;
  logic [39:0] y5;
  logic [4:0]  ov5;
  logic [4:0]  or5;

`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] ec4;
  logic [7:0] ec5;
`endif

  demux_1n_reg #(.N(4), .W(8)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .I         (i4),
    .S         (s4),
    .in_valid  (v4),
    .in_ready  (rdy4),
    .Y         (y4),
    .out_valid (ov4),
    .out_ready (or4)
`ifdef DEMUX_ERR_CNT_EN
    ,
    .err_cnt   (ec4)
`endif
  );

  demux_1n_reg #(.N(5), .W(8)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .I         (i5),
    .S         (s5),
    .in_valid  (v5),
    .in_ready  (rdy5),
    .Y         (y5),
    .out_valid (ov5),
    .out_ready (or5)
`ifdef DEMUX_ERR_CNT_EN
    ,
    .err_cnt   (ec5)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    i4 = '0; s4 = '0; v4 = 1'b0; or4 = '0;
    i5 = '0; s5 = '0; v5 = 1'b0; or5 = '0;
    #1;
    chk("rst_init_valid", ov4, 4'h0);
    chk("rst_init_y", y4, 32'h0);
    chk("rst_init_ready", rdy4, 1'b1);
    chk("rst_init_valid5", ov5, 5'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-stream with channels 1 and 3 full
    v4 = 1'b1; s4 = 2'd1; i4 = 8'hB1;
    tick();
    s4 = 2'd3; i4 = 8'hB3;
    tick();
    v4 = 1'b0; s4 = 2'd1;
    #1;
    chk("pre_rst_valid", ov4, 4'b1010);
    chk("pre_rst_y", y4, 32'hB300_B100);
    chk("pre_rst_stalled_ready", rdy4, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", ov4, 4'h0);
    chk("async_rst_y", y4, 32'h0);
    chk("async_rst_ready", rdy4, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back routing to every channel
    or4 = 4'hF; v4 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      s4 = 2'(s); i4 = 8'hA0 + 8'(s);
      #1;
      chk("route_ready", rdy4, 1'b1);
      tick();
      chk("route_y", y4[s*8 +: 8], 8'hA0 + 8'(s));
      chk("route_valid", ov4[s], 1'b1);
    end
    v4 = 1'b0;
    tick();
    chk("route_drained", ov4, 4'h0);
    chk("route_y_hold", y4, 32'hA3A2_A1A0);

    // Backpressure on channel 2
    or4 = 4'b1011; v4 = 1'b1; s4 = 2'd2; i4 = 8'h11;
    #1;
    chk("bp_first_ready", rdy4, 1'b1);
    tick();
    chk("bp_first_y", y4[23:16], 8'h11);
    chk("bp_first_valid", ov4, 4'b0100);
    i4 = 8'h22;
    #1;
    chk("bp_second_blocked", rdy4, 1'b0);
    tick();
    chk("bp_hold_y", y4[23:16], 8'h11);
    or4 = 4'hF;
    #1;
    chk("bp_release_ready", rdy4, 1'b1);
    tick();
    chk("bp_release_y", y4[23:16], 8'h22);
    chk("bp_release_valid", ov4, 4'b0100);
    v4 = 1'b0;
    tick();
    chk("bp_drained", ov4, 4'h0);

    // Independence: stalled channel 1 does not block channel 3
    or4 = 4'b1101; v4 = 1'b1; s4 = 2'd1; i4 = 8'h44;
    tick();
    chk("ind_ch1_y", y4[15:8], 8'h44);
    i4 = 8'h66;
    #1;
    chk("ind_ch1_blocked", rdy4, 1'b0);
    tick();
    s4 = 2'd3; i4 = 8'h55;
    #1;
    chk("ind_ch3_ready", rdy4, 1'b1);
    tick();
    chk("ind_ch3_y", y4[31:24], 8'h55);
    chk("ind_valid", ov4, 4'b1010);
    chk("ind_ch1_unchanged", y4[15:8], 8'h44);
    v4 = 1'b0; or4 = 4'hF;
    tick();
    chk("ind_drained", ov4, 4'h0);

    // Same-cycle drain and reload on channel 0
    or4 = 4'b1110; v4 = 1'b1; s4 = 2'd0; i4 = 8'h01;
    tick();
    chk("reload_first_y", y4[7:0], 8'h01);
    chk("reload_first_valid", ov4, 4'b0001);
    or4 = 4'hF; i4 = 8'h02;
    #1;
    chk("reload_ready", rdy4, 1'b1);
    tick();
    chk("reload_y", y4[7:0], 8'h02);
    chk("reload_valid", ov4[0], 1'b1);
    v4 = 1'b0;
    tick();
    chk("reload_drained", ov4, 4'h0);
    chk("reload_y_hold", y4[7:0], 8'h02);

    // Out-of-range selects on the 5-channel instance
    or5 = 5'b01111; v5 = 1'b1; s5 = 3'd4; i5 = 8'hC4;
    tick();
    chk("oor_ch4_valid", ov5, 5'b10000);
    s5 = 3'd7;
    for (int j = 0; j < 3; j++) begin
      i5 = 8'hE0 + 8'(j);
      #1;
      chk("oor_ready", rdy5, 1'b1);
      tick();
      chk("oor_valid_unchanged", ov5, 5'b10000);
      chk("oor_ch4_y", y5[39:32], 8'hC4);
    end
`ifdef DEMUX_ERR_CNT_EN
    chk("oor_err_cnt_3", ec5, 8'd3);
`endif
    s5 = 3'd5;
    repeat (300) tick();
    v5 = 1'b0;
    #1;
    chk("oor_bulk_valid", ov5, 5'b10000);
    chk("oor_bulk_y_low", y5[31:0], 32'h0);
    chk("oor_bulk_y_ch4", y5[39:32], 8'hC4);
`ifdef DEMUX_ERR_CNT_EN
    chk("oor_err_cnt_sat", ec5, 8'hFF);
    chk("pow2_err_cnt_zero", ec4, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    chk("err_cnt_rst", ec5, 8'h00);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
